// File: rtl/sys_defs_pkg.sv
// Shared types for the commit path: ROB entry layout, commit/branch-predictor
// packets, FSM state and window-scan stop causes.
package sys_defs;

    localparam int unsigned SYS_N            = 4;
    localparam int unsigned PHYS_REG_SZ_R10K = 64;
    localparam int unsigned ARCH_REG_SZ      = 32;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned ROB_SZ           = 32;
    localparam int unsigned GHR_W            = 8;

    typedef logic [XLEN-1:0]                     DATA;
    typedef logic [XLEN-1:0]                     ADDR;
    typedef logic [$clog2(ROB_SZ)-1:0]           ROB_IDX;
    typedef logic [$clog2(ARCH_REG_SZ)-1:0]      REG_IDX;
    typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PHYS_TAG;
    typedef logic [GHR_W-1:0]                    GHR;

    localparam REG_IDX ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN,
        RECOVER,
        HALTED
    } COMMIT_STATE;

    typedef enum logic [2:0] {
        STOP_NONE,
        STOP_INCOMPLETE,
        STOP_STORE,
        STOP_MISPRED,
        STOP_HALT
    } STOP_CAUSE;

    typedef struct packed {
        logic    complete;
        logic    store;
        logic    branch;
        logic    halt;
        logic    illegal;
        ADDR     pc;
        REG_IDX  arch_rd;
        PHYS_TAG phys_rd;
        PHYS_TAG prev_phys_rd;
        logic    pred_taken;
        ADDR     pred_target;
        logic    actual_taken;
        ADDR     actual_target;
        GHR      ghr_snapshot;
    } ROB_ENTRY;

    typedef struct packed {
        logic   valid;
        logic   halt;
        logic   illegal;
        ADDR    NPC;
        DATA    data;
        REG_IDX reg_idx;
    } COMMIT_PACKET;

    typedef struct packed {
        logic valid;
        ADDR  pc;
        logic taken;
        ADDR  target;
        GHR   ghr;
    } BP_TRAIN_REQUEST;

    typedef struct packed {
        logic pulse;
        GHR   ghr;
    } BP_RECOVER_REQUEST;

    // Per-slot summary consumed by the window scanner.
    typedef struct packed {
        logic valid;
        logic complete;
        logic store;
        logic halt;
        logic mispred;
    } SCAN_SLOT;

    // Wrong direction, or taken to the wrong target.
    function automatic logic is_mispredict(input ROB_ENTRY e);
        return e.branch &&
               ((e.pred_taken != e.actual_taken) ||
                (e.actual_taken && (e.pred_target != e.actual_target)));
    endfunction

endpackage

// File: rtl/commit_engine_scan.sv
// Oldest-first scan of the ROB head window: decides which slots commit this
// cycle, how many ROB entries are popped and why the scan stopped.
module retire_window_scan
    import sys_defs::*;
#(
    parameter int unsigned N        = SYS_N,
    parameter int unsigned ST_PORTS = 1,
    localparam int unsigned CNT_RW  = $clog2(N + 1),
    localparam int unsigned STW     = $clog2(ST_PORTS + 1),
    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  SCAN_SLOT          slots_i [N],
    input  logic              sq_ready_i,
    output logic [N-1:0]      commit_o,
    output logic [CNT_RW-1:0] retire_cnt_o,
    output logic [STW-1:0]    store_cnt_o,
    output logic [IDX_W-1:0]  stop_idx_o,
    output STOP_CAUSE         stop_cause_o
);

    logic scan_done;

    // Walk slots oldest-first; retire count tracks the last committed slot so
    // invalid holes between commits are popped but trailing holes are not.
    always_comb begin
        commit_o     = '0;
        retire_cnt_o = '0;
        store_cnt_o  = '0;
        stop_idx_o   = '0;
        stop_cause_o = STOP_NONE;
        scan_done    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!scan_done && slots_i[i].valid) begin
                if (!slots_i[i].complete) begin
                    scan_done    = 1'b1;
                    stop_idx_o   = IDX_W'(i);
                    stop_cause_o = STOP_INCOMPLETE;
                end else if (slots_i[i].store &&
                             (!sq_ready_i || (32'(store_cnt_o) >= ST_PORTS))) begin
                    scan_done    = 1'b1;
                    stop_idx_o   = IDX_W'(i);
                    stop_cause_o = STOP_STORE;
                end else begin
                    commit_o[i]  = 1'b1;
                    retire_cnt_o = CNT_RW'(i + 1);
                    if (slots_i[i].store) begin
                        store_cnt_o = store_cnt_o + STW'(1);
                    end
                    if (slots_i[i].mispred) begin
                        scan_done    = 1'b1;
                        stop_idx_o   = IDX_W'(i);
                        stop_cause_o = STOP_MISPRED;
                    end else if (slots_i[i].halt) begin
                        scan_done    = 1'b1;
                        stop_idx_o   = IDX_W'(i);
                        stop_cause_o = STOP_HALT;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_engine.sv
// In-order commit stage: retires the ROB head window, updates the arch map,
// free list and checkpoint, trains the branch predictor and handles
// mispredict recovery and halt.
module commit_engine
    import sys_defs::*;
#(
    parameter int unsigned N              = SYS_N,
    parameter int unsigned PHYS_REGS      = PHYS_REG_SZ_R10K,
    parameter int unsigned ARCH_COUNT     = ARCH_REG_SZ,
    parameter int unsigned ST_PORTS       = 1,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  ROB_ENTRY                      head_entries [N],
    input  logic [N-1:0]                  head_valids,
    input  ROB_IDX                        head_idxs [N],
    input  DATA                           regfile_entries [PHYS_REGS],
    input  logic                          sq_commit_ready,
    output logic [$clog2(N+1)-1:0]        retire_cnt,
    output logic [$clog2(ST_PORTS+1)-1:0] sq_commit_cnt,
    output logic                          mispredict,
    output ROB_IDX                        rob_mispred_idx,
    output logic [N-1:0]                  arch_write_enables,
    output REG_IDX                        arch_write_addrs [N],
    output PHYS_TAG                       arch_write_phys_regs [N],
    output logic [PHYS_REGS-1:0]          free_mask,
    output logic [PHYS_REGS-1:0]          freelist_restore_mask,
    output BP_TRAIN_REQUEST               train_req_o,
    output BP_RECOVER_REQUEST             recover_req_o,
    output ADDR                           branch_target_out,
    output COMMIT_PACKET                  retire_commits_dbg [N],
    output logic                          halted,
    output logic [CNT_W-1:0]              retired_total
);

    localparam int unsigned CNT_RW = $clog2(N + 1);
    localparam int unsigned STW    = $clog2(ST_PORTS + 1);
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RCW    = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;
    localparam logic [PHYS_REGS-1:0] CKPT_INIT = {PHYS_REGS{1'b1}} << ARCH_COUNT;

    COMMIT_STATE          state_q, state_d;
    logic [RCW-1:0]       rcnt_q, rcnt_d;
    logic [CNT_W-1:0]     retired_total_q, retired_total_d;
    logic [PHYS_REGS-1:0] ckpt_q, ckpt_d;

    SCAN_SLOT             slots [N];
    logic [N-1:0]         commit_vec;
    logic [CNT_RW-1:0]    scan_cnt;
    logic [STW-1:0]       scan_stores;
    logic [IDX_W-1:0]     stop_idx;
    STOP_CAUSE            stop_cause;
    logic                 run_active;
    logic [CNT_RW-1:0]    n_commit;

    // Reduce each head entry to the flags the scanner needs.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            slots[i] = '{valid:    head_valids[i],
                         complete: head_entries[i].complete,
                         store:    head_entries[i].store,
                         halt:     head_entries[i].halt,
                         mispred:  is_mispredict(head_entries[i])};
        end
    end

    retire_window_scan #(
        .N        (N),
        .ST_PORTS (ST_PORTS)
    ) u_scan (
        .slots_i      (slots),
        .sq_ready_i   (sq_commit_ready),
        .commit_o     (commit_vec),
        .retire_cnt_o (scan_cnt),
        .store_cnt_o  (scan_stores),
        .stop_idx_o   (stop_idx),
        .stop_cause_o (stop_cause)
    );

    // State, recovery counter, retired counter and checkpoint registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= RUN;
            rcnt_q          <= '0;
            retired_total_q <= '0;
            ckpt_q          <= CKPT_INIT;
        end else begin
            state_q         <= state_d;
            rcnt_q          <= rcnt_d;
            retired_total_q <= retired_total_d;
            ckpt_q          <= ckpt_d;
        end
    end

    // Next state: mispredict enters RECOVER for RECOVER_CYCLES, halt is sticky.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            RUN: begin
                if (stop_cause == STOP_MISPRED) begin
                    if (RECOVER_CYCLES != 0) begin
                        state_d = RECOVER;
                        rcnt_d  = RCW'(RECOVER_CYCLES);
                    end
                end else if (stop_cause == STOP_HALT) begin
                    state_d = HALTED;
                end
            end
            RECOVER: begin
                rcnt_d = rcnt_q - RCW'(1);
                if (rcnt_q <= RCW'(1)) begin
                    state_d = RUN;
                    rcnt_d  = '0;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Commit outputs: only driven in RUN and out of reset; also builds the
    // next checkpoint and retired count.
    always_comb begin
        run_active         = reset && (state_q == RUN);
        n_commit           = '0;
        retire_cnt         = '0;
        sq_commit_cnt      = '0;
        mispredict         = 1'b0;
        rob_mispred_idx    = '0;
        arch_write_enables = '0;
        free_mask          = '0;
        train_req_o        = '0;
        recover_req_o      = '0;
        branch_target_out  = '0;
        ckpt_d             = ckpt_q;
        for (int unsigned i = 0; i < N; i++) begin
            arch_write_addrs[i]     = '0;
            arch_write_phys_regs[i] = '0;
            retire_commits_dbg[i]   = '0;
        end

        if (run_active) begin
            retire_cnt    = scan_cnt;
            sq_commit_cnt = scan_stores;
            for (int unsigned i = 0; i < N; i++) begin
                if (commit_vec[i]) begin
                    n_commit = n_commit + CNT_RW'(1);
                    retire_commits_dbg[i].valid   = 1'b1;
                    retire_commits_dbg[i].halt    = head_entries[i].halt;
                    retire_commits_dbg[i].illegal = head_entries[i].illegal;
                    retire_commits_dbg[i].NPC     = head_entries[i].pc + ADDR'(4);
                    retire_commits_dbg[i].reg_idx = head_entries[i].branch ? ZERO_REG
                                                                           : head_entries[i].arch_rd;
                    if (32'(head_entries[i].phys_rd) < PHYS_REGS) begin
                        retire_commits_dbg[i].data = regfile_entries[head_entries[i].phys_rd];
                    end
                    if (head_entries[i].branch) begin
                        // With several branches in one window the youngest trains.
                        train_req_o.valid  = 1'b1;
                        train_req_o.pc     = head_entries[i].pc;
                        train_req_o.taken  = head_entries[i].actual_taken;
                        train_req_o.target = head_entries[i].actual_target;
                        train_req_o.ghr    = head_entries[i].ghr_snapshot;
                        branch_target_out  = head_entries[i].actual_taken
                                           ? head_entries[i].actual_target
                                           : head_entries[i].pc + ADDR'(4);
                    end else if (head_entries[i].arch_rd != ZERO_REG) begin
                        arch_write_enables[i]   = 1'b1;
                        arch_write_addrs[i]     = head_entries[i].arch_rd;
                        arch_write_phys_regs[i] = head_entries[i].phys_rd;
                        if (32'(head_entries[i].phys_rd) < PHYS_REGS) begin
                            ckpt_d[head_entries[i].phys_rd] = 1'b0;
                        end
                        if ((head_entries[i].prev_phys_rd != '0) &&
                            (32'(head_entries[i].prev_phys_rd) < PHYS_REGS)) begin
                            free_mask[head_entries[i].prev_phys_rd] = 1'b1;
                            ckpt_d[head_entries[i].prev_phys_rd]    = 1'b1;
                        end
                    end
                end
            end
            if (stop_cause == STOP_MISPRED) begin
                mispredict          = 1'b1;
                rob_mispred_idx     = head_idxs[stop_idx];
                recover_req_o.pulse = 1'b1;
                recover_req_o.ghr   = head_entries[stop_idx].ghr_snapshot;
            end
        end

        retired_total_d       = retired_total_q + CNT_W'(n_commit);
        freelist_restore_mask = reset ? ckpt_d : '0;
        halted                = (state_q == HALTED);
        retired_total         = retired_total_q;
    end

endmodule

// File: tb/tb_commit_engine.sv
// Directed bench for commit_engine: the driver pushes hand-computed expected
// outputs per cycle into a queue, a monitor pops and compares at negedge.
module tb_commit_engine;
    import sys_defs::*;

    localparam logic [63:0] INIT = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] M1   = 64'hFFC3_FFFF_0000_0000;
    localparam logic [63:0] M3   = 64'hFE43_FFFF_0000_0000;
    localparam logic [63:0] M4   = 64'hFC43_FFFF_0000_0000;
    localparam logic [63:0] M5   = 64'hF843_FFFF_0000_0000;

    logic            clock, reset;
    ROB_ENTRY        head_entries [4];
    logic [3:0]      head_valids;
    ROB_IDX          head_idxs [4];
    DATA             regfile_entries [64];
    logic            sq_commit_ready;
    logic [2:0]      retire_cnt;
    logic [0:0]      sq_commit_cnt;
    logic            mispredict;
    ROB_IDX          rob_mispred_idx;
    logic [3:0]      arch_write_enables;
    REG_IDX          arch_write_addrs [4];
    PHYS_TAG         arch_write_phys_regs [4];
    logic [63:0]     free_mask, freelist_restore_mask;
    BP_TRAIN_REQUEST train_req_o;
    BP_RECOVER_REQUEST recover_req_o;
    ADDR             branch_target_out;
    COMMIT_PACKET    retire_commits_dbg [4];
    logic            halted;
    logic [31:0]     retired_total;

    commit_engine #(
        .N(4), .PHYS_REGS(64), .ARCH_COUNT(32), .ST_PORTS(1), .RECOVER_CYCLES(2), .CNT_W(32)
    ) dut (
        .clock(clock), .reset(reset), .head_entries(head_entries), .head_valids(head_valids),
        .head_idxs(head_idxs), .regfile_entries(regfile_entries), .sq_commit_ready(sq_commit_ready),
        .retire_cnt(retire_cnt), .sq_commit_cnt(sq_commit_cnt), .mispredict(mispredict),
        .rob_mispred_idx(rob_mispred_idx), .arch_write_enables(arch_write_enables),
        .arch_write_addrs(arch_write_addrs), .arch_write_phys_regs(arch_write_phys_regs),
        .free_mask(free_mask), .freelist_restore_mask(freelist_restore_mask),
        .train_req_o(train_req_o), .recover_req_o(recover_req_o),
        .branch_target_out(branch_target_out), .retire_commits_dbg(retire_commits_dbg),
        .halted(halted), .retired_total(retired_total)
    );

    typedef struct packed {
        logic [2:0]  rc;
        logic        sqc;
        logic        mp;
        ROB_IDX      mpidx;
        logic [63:0] free;
        logic [3:0]  we;
        logic        hlt;
        logic [31:0] total;
        logic [63:0] restore;
        logic        rec;
        logic        train;
        ADDR         tgt;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] rc, input logic sqc, input logic mp,
                                input ROB_IDX mpidx, input logic [63:0] free, input logic [3:0] we,
                                input logic hlt, input logic [31:0] total, input logic [63:0] restore,
                                input logic rec, input logic train, input ADDR tgt);
        exp_t x;
        x.rc = rc; x.sqc = sqc; x.mp = mp; x.mpidx = mpidx; x.free = free; x.we = we;
        x.hlt = hlt; x.total = total; x.restore = restore; x.rec = rec; x.train = train; x.tgt = tgt;
        return x;
    endfunction

    function automatic ROB_ENTRY alu(input REG_IDX rd, input PHYS_TAG p, input PHYS_TAG pp,
                                     input logic done);
        ROB_ENTRY e;
        e = '0;
        e.complete = done; e.arch_rd = rd; e.phys_rd = p; e.prev_phys_rd = pp; e.pc = 32'h1000;
        return e;
    endfunction

    function automatic ROB_ENTRY st();
        ROB_ENTRY e;
        e = '0;
        e.complete = 1'b1; e.store = 1'b1; e.pc = 32'h2000;
        return e;
    endfunction

    function automatic ROB_ENTRY br(input ADDR pc, input logic pt, input logic at,
                                    input ADDR ptgt, input ADDR atgt);
        ROB_ENTRY e;
        e = '0;
        e.complete = 1'b1; e.branch = 1'b1; e.pc = pc; e.pred_taken = pt; e.actual_taken = at;
        e.pred_target = ptgt; e.actual_target = atgt; e.ghr_snapshot = 8'h5A;
        return e;
    endfunction

    function automatic ROB_ENTRY hlt_e();
        ROB_ENTRY e;
        e = '0;
        e.complete = 1'b1; e.halt = 1'b1; e.pc = 32'h3000;
        return e;
    endfunction

    task automatic set_win(input ROB_ENTRY e0, input ROB_ENTRY e1, input ROB_ENTRY e2,
                           input ROB_ENTRY e3, input logic [3:0] v, input ROB_IDX base, input logic rdy);
        head_entries[0] = e0; head_entries[1] = e1; head_entries[2] = e2; head_entries[3] = e3;
        head_valids = v;
        for (int i = 0; i < 4; i++) head_idxs[i] = base + ROB_IDX'(i);
        sq_commit_ready = rdy;
    endtask

    task automatic drive(input ROB_ENTRY e0, input ROB_ENTRY e1, input ROB_ENTRY e2,
                         input ROB_ENTRY e3, input logic [3:0] v, input ROB_IDX base,
                         input logic rdy, input exp_t x);
        @(posedge clock);
        #1;
        set_win(e0, e1, e2, e3, v, base, rdy);
        sb.push_back(x);
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("retire_cnt",    64'(retire_cnt),            64'(x.rc));
                check("sq_commit_cnt", 64'(sq_commit_cnt),         64'(x.sqc));
                check("mispredict",    64'(mispredict),            64'(x.mp));
                check("mispred_idx",   64'(rob_mispred_idx),       64'(x.mpidx));
                check("free_mask",     free_mask,                  x.free);
                check("arch_we",       64'(arch_write_enables),    64'(x.we));
                check("halted",        64'(halted),                64'(x.hlt));
                check("retired_total", 64'(retired_total),         64'(x.total));
                check("restore_mask",  freelist_restore_mask,      x.restore);
                check("recover_pulse", 64'(recover_req_o.pulse),   64'(x.rec));
                check("train_valid",   64'(train_req_o.valid),     64'(x.train));
                check("branch_target", 64'(branch_target_out),     64'(x.tgt));
            end
        end
    end

    initial begin
        ROB_ENTRY a1, a2, a3, a4, nop;
        nop = '0;
        a1 = alu(5'd1, 6'd50, 6'd40, 1'b1);
        a2 = alu(5'd2, 6'd51, 6'd41, 1'b1);
        a3 = alu(5'd3, 6'd52, 6'd42, 1'b1);
        a4 = alu(5'd4, 6'd53, 6'd43, 1'b1);
        for (int i = 0; i < 64; i++) regfile_entries[i] = 32'h1000 + 32'(i);

        // Outputs held at zero while in reset, even with a full window.
        reset = 1'b0;
        set_win(a1, a2, a3, a4, 4'b1111, 5'd0, 1'b1);
        sb.push_back(mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd0, '0, 1'b0, 1'b0, '0));
        repeat (2) @(posedge clock);
        #1;
        head_valids = '0;
        reset = 1'b1;

        // Full ALU window.
        drive(a1, a2, a3, a4, 4'b1111, 5'd0, 1'b1,
              mk(3'd4, 1'b0, 1'b0, '0, 64'h0000_0F00_0000_0000, 4'b1111, 1'b0, 32'd0, M1, 1'b0, 1'b0, '0));
        // Empty window.
        drive(nop, nop, nop, nop, 4'b0000, 5'd0, 1'b1,
              mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd4, M1, 1'b0, 1'b0, '0));
        // Three stores, one store port, queue ready.
        drive(st(), st(), st(), nop, 4'b0111, 5'd4, 1'b1,
              mk(3'd1, 1'b1, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd4, M1, 1'b0, 1'b0, '0));
        // Same, queue not ready.
        drive(st(), st(), st(), nop, 4'b0111, 5'd5, 1'b0,
              mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd5, M1, 1'b0, 1'b0, '0));
        // Hole at slot 1, incomplete slot 3.
        drive(alu(5'd6, 6'd55, 6'd45, 1'b1), nop, alu(5'd7, 6'd56, 6'd46, 1'b1),
              alu(5'd8, 6'd60, 6'd47, 1'b0), 4'b1101, 5'd5, 1'b1,
              mk(3'd3, 1'b0, 1'b0, '0, 64'h0000_6000_0000_0000, 4'b0101, 1'b0, 32'd5, M3, 1'b0, 1'b0, '0));
        // Correctly predicted taken branch then ALU.
        drive(br(32'h01F0, 1'b1, 1'b1, 32'h0200, 32'h0200), alu(5'd8, 6'd57, 6'd47, 1'b1), nop, nop,
              4'b0011, 5'd8, 1'b1,
              mk(3'd2, 1'b0, 1'b0, '0, 64'h0000_8000_0000_0000, 4'b0010, 1'b0, 32'd7, M4, 1'b0, 1'b1, 32'h0200));
        // Slot 1 direction mispredict: slots 2,3 must not commit.
        drive(alu(5'd5, 6'd58, 6'd44, 1'b1), br(32'h00F0, 1'b0, 1'b1, 32'h0000, 32'h0100),
              alu(5'd9, 6'd59, 6'd48, 1'b1), alu(5'd10, 6'd60, 6'd49, 1'b1), 4'b1111, 5'd7, 1'b1,
              mk(3'd2, 1'b0, 1'b1, 5'd8, 64'h0000_1000_0000_0000, 4'b0001, 1'b0, 32'd9, M5, 1'b1, 1'b1, 32'h0100));
        // Two recovery cycles commit nothing, then RUN resumes.
        drive(a1, a2, a3, a4, 4'b1111, 5'd9, 1'b1,
              mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd11, M5, 1'b0, 1'b0, '0));
        drive(a1, a2, a3, a4, 4'b1111, 5'd9, 1'b1,
              mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd11, M5, 1'b0, 1'b0, '0));
        drive(a1, a2, a3, a4, 4'b1111, 5'd9, 1'b1,
              mk(3'd4, 1'b0, 1'b0, '0, 64'h0000_0F00_0000_0000, 4'b1111, 1'b0, 32'd11, M5, 1'b0, 1'b0, '0));
        // Slot 0 predicted taken, actually not taken.
        drive(br(32'h0300, 1'b1, 1'b0, 32'h0400, 32'h0400), a2, a3, a4, 4'b1111, 5'd3, 1'b1,
              mk(3'd1, 1'b0, 1'b1, 5'd3, '0, 4'b0000, 1'b0, 32'd15, M5, 1'b1, 1'b1, 32'h0304));
        // First recovery cycle, then asynchronous reset mid-recovery.
        drive(a1, a2, a3, a4, 4'b1111, 5'd13, 1'b1,
              mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd16, M5, 1'b0, 1'b0, '0));
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_state",   64'(dut.state_q),        64'(RUN));
        check("rst_rcnt",    64'(dut.rcnt_q),         64'd0);
        check("rst_ckpt",    dut.ckpt_q,              INIT);
        check("rst_retire",  64'(retire_cnt),         64'd0);
        check("rst_total",   64'(retired_total),      64'd0);
        check("rst_restore", freelist_restore_mask,   64'd0);
        head_valids = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd0, INIT, 1'b0, 1'b0, '0));

        // Halt in slot 0 blocks slot 1 and latches HALTED.
        drive(hlt_e(), a1, nop, nop, 4'b0011, 5'd0, 1'b1,
              mk(3'd1, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 32'd0, INIT, 1'b0, 1'b0, '0));
        drive(a1, a2, a3, a4, 4'b1111, 5'd2, 1'b1,
              mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b1, 32'd1, INIT, 1'b0, 1'b0, '0));
        drive(a1, a2, a3, a4, 4'b1111, 5'd2, 1'b1,
              mk(3'd0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b1, 32'd1, INIT, 1'b0, 1'b0, '0));

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
